// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-style request/response bundle between the CPU core and its responder.
// The core (master) drives the request fields; the responder (slave) returns registered read data.
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM port responder: scratch RAM, LED/NUM regs, synchronized switches, timer with compare IRQ.
// 1-cycle read latency with read-before-write; no backpressure, a request is accepted every cycle.
module data_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hBFAF_0000,
  parameter int          RAM_WORDS = 256
) (
  input  logic                       clk,
  input  logic                       resetn,
  data_sram_responder_if.slave       bus,
  input  logic [15:0]                switch,
  output logic [15:0]                led,
  output logic [31:0]                num_data,
  output logic                       timer_int
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Register offsets as word indices (addr[15:2]).
  localparam logic [13:0] OFF_LED   = 14'h3C00;
  localparam logic [13:0] OFF_NUM   = 14'h3C04;
  localparam logic [13:0] OFF_SW    = 14'h3C08;
  localparam logic [13:0] OFF_TIMER = 14'h3C0C;
  localparam logic [13:0] OFF_CMP   = 14'h3C0D;
  localparam logic [13:0] OFF_IRQ   = 14'h3C0E;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] rdata_q;
  logic [15:0] led_q;
  logic [31:0] num_q;
  logic [31:0] timer_q;
  logic [31:0] cmp_q;
  logic        irq_q;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;

  logic [13:0]   word;
  logic [AW-1:0] ram_idx;
  logic          hit;
  logic          wr;
  logic          ram_sel;
  logic          led_we;
  logic          num_we;
  logic          timer_we;
  logic          cmp_we;
  logic          irq_we;
  logic          irq_set;
  logic          irq_clr;
  logic [31:0]   rd_val;
  logic [31:0]   led_mrg;
  logic [31:0]   num_mrg;
  logic [31:0]   timer_mrg;
  logic [31:0]   cmp_mrg;
  logic [31:0]   timer_next;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  assign word    = bus.data_sram_addr[15:2];
  assign ram_idx = word[AW-1:0];
  assign hit     = (bus.data_sram_addr[31:16] == BASE_ADDR[31:16]);
  assign wr      = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
  assign ram_sel = hit && (word < 14'(RAM_WORDS));

  assign led_we   = wr && hit && (word == OFF_LED);
  assign num_we   = wr && hit && (word == OFF_NUM);
  assign timer_we = wr && hit && (word == OFF_TIMER);
  assign cmp_we   = wr && hit && (word == OFF_CMP);
  assign irq_we   = wr && hit && (word == OFF_IRQ);

  assign led_mrg   = byte_merge({16'h0000, led_q}, bus.data_sram_wdata, bus.data_sram_wen);
  assign num_mrg   = byte_merge(num_q,   bus.data_sram_wdata, bus.data_sram_wen);
  assign timer_mrg = byte_merge(timer_q, bus.data_sram_wdata, bus.data_sram_wen);
  assign cmp_mrg   = byte_merge(cmp_q,   bus.data_sram_wdata, bus.data_sram_wen);

  // A timer write replaces the increment for that cycle and also masks the match.
  assign timer_next = timer_we ? timer_mrg : timer_q + 32'd1;
  assign irq_set    = !timer_we && (timer_q == cmp_q);
  assign irq_clr    = irq_we && bus.data_sram_wen[0] && bus.data_sram_wdata[0];

  always_comb begin
    rd_val = 32'h0;
    if (ram_sel) begin
      rd_val = ram[ram_idx];
    end else if (hit) begin
      case (word)
        OFF_LED:   rd_val = {16'h0000, led_q};
        OFF_NUM:   rd_val = num_q;
        OFF_SW:    rd_val = {16'h0000, sw_sync};
        OFF_TIMER: rd_val = timer_q;
        OFF_CMP:   rd_val = cmp_q;
        OFF_IRQ:   rd_val = {31'h0, irq_q};
        default:   rd_val = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q <= 32'h0;
      led_q   <= 16'h0;
      num_q   <= 32'h0;
      timer_q <= 32'h0;
      cmp_q   <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
      sw_meta <= 16'h0;
      sw_sync <= 16'h0;
    end else begin
      if (bus.data_sram_en) rdata_q <= rd_val;
      if (led_we)           led_q   <= led_mrg[15:0];
      if (num_we)           num_q   <= num_mrg;
      if (cmp_we)           cmp_q   <= cmp_mrg;
      timer_q <= timer_next;
      irq_q   <= irq_set | (irq_q & ~irq_clr);
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // RAM is not reset; writes are only suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (resetn && wr && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_wen[i]) ram[ram_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign led                 = led_q;
  assign num_data            = num_q;
  assign timer_int           = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: directed steps plus random traffic against a behavioural model.
module tb_data_sram_responder;

  localparam logic [31:0] BASE      = 32'hBFAF_0000;
  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] A_LED   = BASE | 32'hF000;
  localparam logic [31:0] A_NUM   = BASE | 32'hF010;
  localparam logic [31:0] A_SW    = BASE | 32'hF020;
  localparam logic [31:0] A_TIMER = BASE | 32'hF030;
  localparam logic [31:0] A_CMP   = BASE | 32'hF034;
  localparam logic [31:0] A_IRQ   = BASE | 32'hF038;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] sw;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_int;

  data_sram_responder_if bus ();

  data_sram_responder #(.BASE_ADDR(BASE), .RAM_WORDS(RAM_WORDS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .switch    (sw),
    .led       (led),
    .num_data  (num_data),
    .timer_int (timer_int)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [31:0] m_ram [RAM_WORDS];
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [31:0] m_cmp;
  logic        m_irq;
  logic [15:0] m_sw1;
  logic [15:0] m_sw2;
  logic [31:0] m_rdata;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] w);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_num = 32'h0; m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF;
    m_irq = 1'b0; m_sw1 = 16'h0; m_sw2 = 16'h0; m_rdata = 32'h0;
  endtask

  // Applies one clock edge of the address-map rules to the model state.
  task automatic model_edge();
    logic [31:0] a, d, rv, tmp;
    logic [3:0]  w;
    logic        e, hit, wr, t_wr, clr;
    logic [15:0] off;
    int          idx;
    if (!resetn) return;
    e = bus.data_sram_en; w = bus.data_sram_wen; a = bus.data_sram_addr; d = bus.data_sram_wdata;
    off = {a[15:2], 2'b00};
    idx = int'(a[15:2]);
    hit = (a[31:16] == BASE[31:16]);
    wr  = e && (w != 4'h0);
    rv  = 32'h0;
    if (hit) begin
      if (idx < RAM_WORDS) rv = m_ram[idx];
      else case (off)
        16'hF000: rv = {16'h0, m_led};
        16'hF010: rv = m_num;
        16'hF020: rv = {16'h0, m_sw2};
        16'hF030: rv = m_timer;
        16'hF034: rv = m_cmp;
        16'hF038: rv = {31'h0, m_irq};
        default:  rv = 32'h0;
      endcase
    end
    t_wr  = wr && hit && (off == 16'hF030);
    clr   = wr && hit && (off == 16'hF038) && w[0] && d[0];
    m_irq = ((m_timer == m_cmp) && !t_wr) || (m_irq && !clr);
    m_timer = t_wr ? bmerge(m_timer, d, w) : m_timer + 32'd1;
    if (wr && hit) begin
      if (idx < RAM_WORDS) m_ram[idx] = bmerge(m_ram[idx], d, w);
      else case (off)
        16'hF000: begin tmp = bmerge({16'h0, m_led}, d, w); m_led = tmp[15:0]; end
        16'hF010: m_num = bmerge(m_num, d, w);
        16'hF034: m_cmp = bmerge(m_cmp, d, w);
        default: ;
      endcase
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
    if (e) m_rdata = rv;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rdata",     bus.data_sram_rdata, m_rdata);
    check("led",       {16'h0, led},        {16'h0, m_led});
    check("num_data",  num_data,            m_num);
    check("timer_int", {31'h0, timer_int},  {31'h0, m_irq});
  endtask

  // Drive one request just after an edge, let the next edge take it, then compare.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    bus.data_sram_en = e; bus.data_sram_wen = w; bus.data_sram_addr = a; bus.data_sram_wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.data_sram_en = 1'b0; bus.data_sram_wen = 4'h0;
    bus.data_sram_addr = 32'h0; bus.data_sram_wdata = 32'h0; sw = 16'h0;
    #1 resetn = 1'b0;
    model_reset();
    #1;
    check("reset_rdata", bus.data_sram_rdata, 32'h0);
    check("reset_led",   {16'h0, led}, 32'h0);
    check("reset_num",   num_data, 32'h0);
    check("reset_irq",   {31'h0, timer_int}, 32'h0);
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;

    step(1'b1, 4'h0, A_CMP, 32'h0);
    check("cmp_reset_read", bus.data_sram_rdata, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, A_IRQ, 32'h0);
    check("irq_reset_read", bus.data_sram_rdata, 32'h0);

    for (int i = 0; i < RAM_WORDS; i++) step(1'b1, 4'hF, BASE + 32'(i * 4), $urandom);

    // RAM byte merge and back-to-back reads
    step(1'b1, 4'hF,    BASE | 32'h10, 32'h1234_5678);
    step(1'b1, 4'b0010, BASE | 32'h10, 32'hAABB_CCDD);
    step(1'b1, 4'hF,    BASE | 32'h14, 32'h0);
    step(1'b1, 4'h0,    BASE | 32'h10, 32'h0);
    check("ram_merge", bus.data_sram_rdata, 32'h1234_CC78);
    step(1'b1, 4'h0,    BASE | 32'h14, 32'h0);
    check("ram_b2b", bus.data_sram_rdata, 32'h0);

    // Read-before-write on LED, then idle hold
    step(1'b1, 4'hF, A_LED, 32'h0000_0003);
    step(1'b1, 4'hF, A_LED, 32'hFFFF_00F0);
    check("led_rbw_rdata", bus.data_sram_rdata, 32'h3);
    check("led_value", {16'h0, led}, 32'h00F0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      check("rdata_hold", bus.data_sram_rdata, 32'h3);
    end

    // Timer compare match latency and clear
    step(1'b1, 4'hF, A_CMP, 32'h100);
    step(1'b1, 4'hF, A_TIMER, 32'hF0);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 4'h0, 32'h0, 32'h0);
      if (timer_int && lat == 0) lat = k;
    end
    check("irq_latency", 32'(lat), 32'd17);
    step(1'b1, 4'b0001, A_IRQ, 32'h1);
    check("irq_clear", {31'h0, timer_int}, 32'h0);
    step(1'b1, 4'hF, A_TIMER, 32'hF0);
    for (int k = 1; k <= 16; k++) step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'b0001, A_IRQ, 32'h1);
    check("irq_set_wins", {31'h0, timer_int}, 32'h1);

    // Timer wrap and partial write without increment
    step(1'b1, 4'hF, A_TIMER, 32'hFFFF_FFFE);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_pre_wrap", bus.data_sram_rdata, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_wrap", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'hF,    A_TIMER, 32'hCAFE_BA00);
    step(1'b1, 4'b0001, A_TIMER, 32'h0000_005A);
    check("timer_rbw", bus.data_sram_rdata, 32'hCAFE_BA00);
    step(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_byte_write", bus.data_sram_rdata, 32'hCAFE_BA5A);

    // Switch synchronizer and address decode
    sw = 16'hA5A5;
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_read", bus.data_sram_rdata, 32'h0000_A5A5);
    step(1'b1, 4'h0, BASE | 32'hF0FC, 32'h0);
    check("unmapped_read", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, 32'h1FAF_F000, 32'h0);
    check("off_base_read", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'hF, BASE | 32'hF0FC, 32'hFFFF_FFFF);
    step(1'b1, 4'hF, 32'h1FAF_F000, 32'hFFFF_FFFF);
    step(1'b1, 4'hF, 32'h1FAF_F010, 32'hFFFF_FFFF);
    step(1'b1, 4'hF, 32'h1FAF_0010, 32'hDEAD_BEEF);
    step(1'b1, 4'h0, A_LED, 32'h0);
    check("led_untouched", bus.data_sram_rdata, 32'h0000_00F0);
    step(1'b1, 4'h0, A_NUM, 32'h0);
    check("num_untouched", bus.data_sram_rdata, 32'h0);
    step(1'b1, 4'h0, BASE | 32'h10, 32'h0);
    check("ram_untouched", bus.data_sram_rdata, 32'h1234_CC78);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r, a, d;
      logic [3:0]  w;
      logic        e;
      r = $urandom; d = $urandom;
      e = ($urandom_range(0, 99) < 85);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 11))
        0, 1, 2, 3: a = BASE + 32'($urandom_range(0, RAM_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
        4:  a = A_LED;
        5:  a = A_NUM;
        6:  a = A_SW;
        7:  a = A_TIMER;
        8:  a = A_IRQ;
        9:  a = {16'hBFAF, r[15:0]};
        10: begin a = A_CMP; w = 4'hF; e = 1'b1; d = m_timer + 32'($urandom_range(2, 12)); end
        default: a = r;
      endcase
      if ($urandom_range(0, 31) == 0) sw = r[31:16];
      step(e, w, a, d);
    end

    // Async reset in the middle of a NUM write stream
    step(1'b1, 4'hF, A_CMP, 32'h20);
    step(1'b1, 4'hF, A_TIMER, 32'h10);
    for (int k = 0; k < 20; k++) step(1'b0, 4'h0, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'hF, A_NUM, $urandom | 32'h1);
    bus.data_sram_en = 1'b1; bus.data_sram_wen = 4'hF;
    bus.data_sram_addr = A_NUM; bus.data_sram_wdata = 32'h5555_AAAA;
    #3 resetn = 1'b0;
    #1;
    check("arst_num",   num_data, 32'h0);
    check("arst_rdata", bus.data_sram_rdata, 32'h0);
    check("arst_irq",   {31'h0, timer_int}, 32'h0);
    model_reset();
    step(1'b1, 4'hF, A_NUM, 32'h1234_0000);
    step(1'b1, 4'hF, A_NUM, 32'h0000_4321);
    resetn = 1'b1;
    step(1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_after_reset", bus.data_sram_rdata, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Memory-mapped responder for the CPU core's data-side SRAM-style port (`data_sram_en` / `data_sram_wen` / `data_sram_addr` / `data_sram_wdata` / `data_sram_rdata`). The port is driven by the core, and this block answers it with synchronous-SRAM timing. It holds the following resources:
- a byte-writable scratch RAM;
- LED and number-display registers;
- a synchronized switch input;
- a free-running timer with compare match.

The timer interrupt output connects to one bit of the core's `ext_int`.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hBFAF_0000: a request is decoded only when `addr[31:16] == BASE_ADDR[31:16]`.
- `RAM_WORDS`, default 256: scratch RAM depth in 32-bit words, power of two, at most 1024.

Ports. One clock; reset is asynchronous and active-low.
- `clk`, in, 1: clock. All state changes on the rising edge.
- `resetn`, in, 1: asynchronous reset, active-low.
- `data_sram_en`, in, 1: request valid this cycle.
- `data_sram_wen`, in, 4: byte write enables; nonzero means write. Bit i enables `wdata[8i+7:8i]`.
- `data_sram_addr`, in, 32: byte address; bits [1:0] are ignored.
- `data_sram_wdata`, in, 32: write data.
- `data_sram_rdata`, out, 32: registered read data.
- `switch`, in, 16: asynchronous board switches.
- `led`, out, 16: `LED[15:0]`.
- `num_data`, out, 32: `NUM` register.
- `timer_int`, out, 1: level interrupt, equal to `IRQ[0]`.

## Operation
Address map. Offsets are `addr[15:0]`.
- 0x0000 to 4*`RAM_WORDS`-4, `RAM`: read/write with byte enables. Contents are not reset.
- 0xF000, `LED`: read/write with byte enables. Reset value 0.
- 0xF010, `NUM`: read/write with byte enables. Reset value 0.
- 0xF020, `SWITCH`: read-only. Reads `{16'b0, sw_sync}`, where `sw_sync` is `switch` after a 2-flop synchronizer (reset value 0).
- 0xF030, `TIMER`: read/write with byte enables. Reset value 0.
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - On a write cycle it loads the byte-merged value (old value with the enabled bytes replaced) and does not increment that cycle.
- 0xF034, `COMPARE`: read/write with byte enables. Reset value 0xFFFF_FFFF.
- 0xF038, `IRQ`: bit0 only; upper bits read 0. Reset value 0.
  - Set on the cycle after `TIMER == COMPARE`, evaluated on current register values and only when `TIMER` is not being written that cycle.
  - Write-1-to-clear via byte 0. If set and clear occur in the same cycle, set wins.
- Unmapped offsets and out-of-base addresses: reads return 0, writes are ignored.

Request handling:
- `en=1`, `wen=0`: read. `rdata` is loaded at the next edge with the addressed value.
- `en=1`, `wen!=0`: write, applied at the edge. `rdata` is loaded with the pre-write value (read-before-write).
- `en=0`: no access. `rdata` holds its last value.

## Timing
- Read latency is 1 cycle: address presented in cycle N, `rdata` valid from cycle N+1 until the next cycle with `en=1`.
- Every cycle accepts a request. There is no stall or backpressure, so back-to-back requests give one `rdata` update per cycle.
- Write effects are visible to a read issued in the next cycle.
- `led`, `num_data` and `timer_int` come directly from registers. They change in the cycle after the write or match that causes them.
- `switch` to `SWITCH` read: a change at `switch` is guaranteed visible to a read issued 2 cycles later (3 cycles to `rdata`).
- Reset:
  - `resetn` low immediately forces `rdata`=0, `led`=0, `num_data`=0, `timer_int`=0, `TIMER`=0, `COMPARE`=0xFFFF_FFFF, `IRQ`=0 and the synchronizer to 0, including mid-access.
  - Any access in flight is discarded. RAM keeps its contents.
  - After release, `TIMER` starts counting on the first edge with `resetn` high.

## Test plan
- RAM byte merge: write 0x10 with `wen`=1111 and `wdata`=0x12345678, then write 0x10 with `wen`=0010 and `wdata`=0xAABBCCDD, then read 0x10. Required: `rdata`=0x1234CC78 one cycle after the read. Back-to-back reads of 0x10 and 0x14 (after writing 0x14=0x0) give 0x1234CC78 then 0x0 on consecutive cycles.
- Read-before-write: with `LED`=0x0003, write `LED`=0xFFFF00F0 with `wen`=1111. Required: next-cycle `rdata`=0x00000003 and `led`=0x00F0. Then hold `en`=0 for 5 cycles. Required: `rdata` is unchanged.
- Timer and interrupt:
  - Write `COMPARE`=0x100, then `TIMER`=0xF0. Required: `timer_int` rises exactly 17 cycles after the `TIMER` write edge.
  - Write `IRQ`=1. Required: `timer_int`=0 next cycle.
  - Repeat with the clear coinciding with a match. Required: `timer_int` stays 1.
- Timer wrap and write priority:
  - Write `TIMER`=0xFFFF_FFFE, then read `TIMER` 1 cycle later. Required: 0xFFFF_FFFF.
  - Read 2 cycles later. Required: 0x0000_0000.
  - Write `TIMER` with `wen`=0001 and data 0x5A. Required: only byte 0 is replaced and there is no increment that cycle.
- Switch and decode: drive `switch`=0xA5A5 and read 0xF020 3 cycles later. Required: 0x0000A5A5. Reads of offset 0xF0FC and of address 0x1FAF_F000 return 0, and writes to both leave `LED`, `NUM` and RAM unchanged.
- Async reset mid-traffic: drop `resetn` between edges during a `NUM` write stream. Required: `num_data`=0, `rdata`=0 and `timer_int`=0 before the next edge. After release, `TIMER` reads 1 when read on the first post-reset cycle.
